// File: rtl/frame_scan_capture.sv
// Receiver for row-scanned 16x16 panel beats: collects rows into a shadow buffer and commits whole frames.
// Optional LIVE_COUNT_EN adds a popcount of each committed frame on LiveCount.
module frame_scan_capture #(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    localparam int RW = $clog2(ROWS)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    input  logic [RW-1:0]        InRow,
    input  logic [COLS-1:0]      InData,
    output logic [ROWS*COLS-1:0] Frame,
    output logic                 FrameDone,
    output logic                 SyncErr,
    output logic [7:0]           FrameCount,
    output logic [7:0]           ErrCount,
    output logic [8:0]           LiveCount,
    output logic                 DbgState
);
    typedef enum logic {SYNC = 1'b0, CAPTURE = 1'b1} state_t;

    // Handshake: a beat is InValid high on a Clock edge; there is no ready, every valid beat is consumed.
    state_t                 state_q;
    logic [RW-1:0]          exp_row_q;
    logic [COLS-1:0]        shadow_q [ROWS];
    logic [ROWS*COLS-1:0]   frame_q;
    logic                   done_q;
    logic                   err_q;
    logic [7:0]             fcnt_q;
    logic [7:0]             ecnt_q;
    logic [ROWS*COLS-1:0]   commit_frame_d;
    logic                   in_order;
    logic                   last_row;
    logic                   commit;

    // The last row is merged straight from the input so the commit needs no extra cycle.
    always_comb begin
        commit_frame_d = '0;
        for (int i = 0; i < ROWS; i++) begin
            commit_frame_d[i*COLS +: COLS] = (i == ROWS-1) ? InData : shadow_q[i];
        end
    end

    assign in_order = InValid && (state_q == CAPTURE) && (InRow == exp_row_q);
    assign last_row = (InRow == RW'(ROWS-1));
    assign commit   = in_order && last_row;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= SYNC;
            exp_row_q <= '0;
            for (int i = 0; i < ROWS; i++) shadow_q[i] <= '0;
            frame_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (InValid) begin
                case (state_q)
                    SYNC: begin
                        if (InRow == '0) begin
                            shadow_q[0] <= InData;
                            exp_row_q   <= RW'(1);
                            state_q     <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (InRow == exp_row_q) begin
                            shadow_q[InRow] <= InData;
                            exp_row_q       <= exp_row_q + RW'(1);
                            if (last_row) begin
                                frame_q   <= commit_frame_d;
                                done_q    <= 1'b1;
                                fcnt_q    <= fcnt_q + 8'd1;
                                exp_row_q <= '0;
                                state_q   <= SYNC;
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
                            if (InRow == '0) begin
                                shadow_q[0] <= InData;
                                exp_row_q   <= RW'(1);
                            end else begin
                                exp_row_q <= '0;
                                state_q   <= SYNC;
                            end
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

`ifdef LIVE_COUNT_EN
    logic [8:0] live_d;
    logic [8:0] live_q;

    always_comb begin
        live_d = '0;
        for (int k = 0; k < ROWS*COLS; k++) live_d = live_d + {8'd0, commit_frame_d[k]};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)       live_q <= '0;
        else if (commit) live_q <= live_d;
    end

    assign LiveCount = live_q;
`else
    assign LiveCount = 9'd0;
`endif

    assign Frame      = frame_q;
    assign FrameDone  = done_q;
    assign SyncErr    = err_q;
    assign FrameCount = fcnt_q;
    assign ErrCount   = ecnt_q;
    assign DbgState   = state_q;
endmodule

// File: tb/tb_frame_scan_capture.sv
// Bench for frame_scan_capture: a reference model predicts each beat, expected frames queue up and are
// popped on FrameDone.
module tb_frame_scan_capture;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_row;
    logic [15:0]  in_data;
    logic [255:0] frame;
    logic         frame_done;
    logic         sync_err;
    logic [7:0]   frame_count;
    logic [7:0]   err_count;
    logic [8:0]   live_count;
    logic         dbg_state;

    frame_scan_capture dut (
        .Clock(clk), .Reset(rst), .InValid(in_valid), .InRow(in_row), .InData(in_data),
        .Frame(frame), .FrameDone(frame_done), .SyncErr(sync_err), .FrameCount(frame_count),
        .ErrCount(err_count), .LiveCount(live_count), .DbgState(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done_cyc = 0;

    logic [255:0] exp_q[$];

    // reference model state
    bit           m_sync;
    int           m_exp;
    logic [15:0]  m_shadow [16];
    logic [255:0] m_frame;
    logic [7:0]   m_fc;
    logic [7:0]   m_ec;
    logic [8:0]   m_live;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [8:0] exp_live(input logic [8:0] v);
`ifdef LIVE_COUNT_EN
        return v;
`else
        return 9'd0;
`endif
    endfunction

    task automatic model_reset();
        m_sync = 1'b1;
        m_exp  = 0;
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;
        m_frame = '0;
        m_fc = '0;
        m_ec = '0;
        m_live = '0;
        exp_q.delete();
    endtask

    // driver: one cycle, model predicts, then outputs are checked 1ns after the edge
    task automatic drive(input bit v, input int row, input logic [15:0] d);
        bit e_done = 0;
        bit e_err  = 0;
        @(negedge clk);
        in_valid = v;
        in_row   = 4'(row);
        in_data  = d;
        if (v) begin
            if (m_sync) begin
                if (row == 0) begin m_shadow[0] = d; m_exp = 1; m_sync = 0; end
            end else if (row == m_exp) begin
                m_shadow[row] = d;
                m_exp++;
                if (row == 15) begin
                    for (int i = 0; i < 16; i++) m_frame[i*16 +: 16] = m_shadow[i];
                    m_live = 9'($countones(m_frame));
                    m_fc = m_fc + 8'd1;
                    m_exp = 0;
                    m_sync = 1;
                    e_done = 1;
                    exp_q.push_back(m_frame);
                end
            end else begin
                e_err = 1;
                if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                if (row == 0) begin m_shadow[0] = d; m_exp = 1; end
                else begin m_exp = 0; m_sync = 1; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("frame_done", 256'(frame_done), 256'(e_done));
        check("sync_err", 256'(sync_err), 256'(e_err));
        if (frame_done) begin
            last_done_cyc = cyc;
            if (exp_q.size() == 0) check("exp_q_underflow", 256'(1), 256'(0));
            else check("frame_commit", frame, exp_q.pop_front());
        end else if (e_done && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        check("frame_held", frame, m_frame);
        check("frame_count", 256'(frame_count), 256'(m_fc));
        check("err_count", 256'(err_count), 256'(m_ec));
        check("live_count", 256'(live_count), 256'(exp_live(m_live)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, $urandom_range(0, 15), 16'($urandom));
    endtask

    task automatic send_frame(input logic [15:0] rows [16]);
        for (int r = 0; r < 16; r++) drive(1, r, rows[r]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame"}, frame, '0);
        check({tag, "_done"}, 256'(frame_done), 256'(0));
        check({tag, "_err"}, 256'(sync_err), 256'(0));
        check({tag, "_fc"}, 256'(frame_count), 256'(0));
        check({tag, "_ec"}, 256'(err_count), 256'(0));
        check({tag, "_live"}, 256'(live_count), 256'(0));
        check({tag, "_state"}, 256'(dbg_state), 256'(0));
    endtask

    initial begin
        logic [15:0]  rows [16];
        logic [255:0] diag;
        int           done_a;

        in_valid = 0; in_row = 0; in_data = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: diagonal frame
        for (int r = 0; r < 16; r++) rows[r] = 16'h0001 << r;
        send_frame(rows);
        diag = '0;
        for (int r = 0; r < 16; r++) diag[r*16 + r] = 1'b1;
        check("t1_diag", frame, diag);
        check("t1_fc", 256'(frame_count), 256'(1));
        check("t1_live", 256'(live_count), 256'(exp_live(9'd16)));

        // 2: out-of-order nonzero row drops the partial frame
        for (int r = 0; r < 6; r++) drive(1, r, 16'hA5A5);
        drive(1, 9, 16'h1234);
        check("t2_ec", 256'(err_count), 256'(1));
        check("t2_frame_kept", frame, diag);
        for (int r = 0; r < 16; r++) rows[r] = 16'($urandom);
        send_frame(rows);

        // 3: early row 0 restarts capture with the new row-0 data
        for (int r = 0; r < 8; r++) drive(1, r, 16'h1111);
        drive(1, 0, 16'hBEEF);
        check("t3_ec", 256'(err_count), 256'(2));
        for (int r = 1; r < 16; r++) drive(1, r, 16'(r * 3));
        check("t3_row0", 256'(frame[15:0]), 256'(16'hBEEF));

        // 4: back-to-back all-ones then all-zeros
        for (int r = 0; r < 16; r++) rows[r] = 16'hFFFF;
        send_frame(rows);
        done_a = last_done_cyc;
        check("t4_a_ones", frame, {256{1'b1}});
        check("t4_a_live", 256'(live_count), 256'(exp_live(9'd256)));
        for (int r = 0; r < 16; r++) rows[r] = 16'h0000;
        send_frame(rows);
        check("t4_spacing", 256'(last_done_cyc - done_a), 256'(16));
        check("t4_b_zero", frame, '0);
        check("t4_b_live", 256'(live_count), 256'(exp_live(9'd0)));
        check("t4_fc", 256'(frame_count), 256'(5));

        // 5: asynchronous reset mid-frame
        for (int r = 0; r < 16; r++) rows[r] = 16'h00FF;
        send_frame(rows);
        for (int r = 0; r < 11; r++) drive(1, r, 16'hF0F0);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int r = 11; r < 16; r++) drive(1, r, 16'hF0F0);
        check("t5_no_commit", frame, '0);

        // 6: stray rows, random gaps, then error saturation
        drive(1, 3, 16'h0303);
        drive(1, 7, 16'h0707);
        check("t6_stray_ec", 256'(err_count), 256'(0));
        for (int r = 0; r < 16; r++) begin
            idle($urandom_range(0, 3));
            drive(1, r, 16'($urandom));
        end
        check("t6_ec_zero", 256'(err_count), 256'(0));
        check("t6_fc", 256'(frame_count), 256'(1));
        drive(1, 0, 16'h0);
        for (int i = 0; i < 300; i++) drive(1, 0, 16'(i));
        check("t6_ec_sat", 256'(err_count), 256'(255));
        check("t6_state", 256'(dbg_state), 256'(1));
        idle(2);

        check("exp_q_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
